// File: rtl/bemf_integrator.sv
// Multi-channel back-EMF integrator: 4-stage pipeline from ADC sample pair to
// calibrated, deadbanded velocity and a saturating per-channel position accumulator.
module bemf_integrator #(
  parameter int NUM_CH   = 4,
  parameter int ADC_W    = 10,
  parameter int ACC_W    = 20,
  parameter int DEADBAND = 20,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [ADC_W-1:0]  adc_h,
  input  logic [ADC_W-1:0]  adc_l,
  input  logic              calib_we,
  input  logic [CH_W-1:0]   calib_ch,
  input  logic [ACC_W-1:0]  calib_data,
  input  logic              clr_valid,
  input  logic [CH_W-1:0]   clr_ch,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  pos_out,
  output logic [ACC_W-1:0]  vel_out,
  output logic [NUM_CH-1:0] sat_flags
);

  // in_valid/out_valid are one-cycle strobes with no back-pressure: every
  // cycle with in_valid high carries one sample, every out_valid cycle one result.

  localparam int PAD = ACC_W + 1 - ADC_W;
  localparam logic signed [ACC_W-1:0] DB_POS = ACC_W'(DEADBAND);
  localparam logic signed [ACC_W-1:0] DB_NEG = -DB_POS;

  function automatic logic [ACC_W-1:0] clamp(input logic [ACC_W:0] x);
    if (x[ACC_W] != x[ACC_W-1])
      clamp = x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      clamp = x[ACC_W-1:0];
  endfunction

  logic              s0_valid, s1_valid, s2_valid;
  logic [CH_W-1:0]   s0_ch, s1_ch, s2_ch;
  logic [ADC_W-1:0]  s0_h, s0_l;
  logic [ACC_W:0]    s1_diff;
  logic [ACC_W-1:0]  s2_cal;
  logic [ACC_W-1:0]  calib [NUM_CH];
  logic [ACC_W-1:0]  acc   [NUM_CH];

  logic [ACC_W:0]    diff_c, cal_full, sum_full;
  logic [ACC_W-1:0]  calib_rd, acc_rd, vel_c, sum_sat;
  logic              vel_pass, sum_ovf, clr_hit;

  always_comb begin
    diff_c   = {{PAD{1'b0}}, s0_h} - {{PAD{1'b0}}, s0_l};
    calib_rd = calib[s1_ch];
    cal_full = s1_diff - {calib_rd[ACC_W-1], calib_rd};
    vel_pass = ($signed(s2_cal) > DB_POS) || ($signed(s2_cal) < DB_NEG);
    vel_c    = vel_pass ? s2_cal : '0;
    acc_rd   = acc[s2_ch];
    sum_full = {acc_rd[ACC_W-1], acc_rd} + {vel_c[ACC_W-1], vel_c};
    sum_ovf  = sum_full[ACC_W] ^ sum_full[ACC_W-1];
    sum_sat  = clamp(sum_full);
    clr_hit  = clr_valid && (clr_ch == s2_ch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_ch    <= '0;
      s0_h     <= '0;
      s0_l     <= '0;
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_diff  <= '0;
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_cal   <= '0;
    end else begin
      s0_valid <= in_valid;
      s0_ch    <= in_ch;
      s0_h     <= adc_h;
      s0_l     <= adc_l;
      s1_valid <= s0_valid;
      s1_ch    <= s0_ch;
      s1_diff  <= diff_c;
      s2_valid <= s1_valid;
      s2_ch    <= s1_ch;
      s2_cal   <= clamp(cal_full);
    end
  end

  // calib is read combinationally by S1, so a write landing on the same edge is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) calib[i] <= '0;
    end else if (calib_we) begin
      calib[calib_ch] <= calib_data;
    end
  end

  // The later clear assignment overrides the S3 write when both hit one channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      sat_flags <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      pos_out   <= '0;
      vel_out   <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        acc[s2_ch] <= sum_sat;
        if (sum_ovf) sat_flags[s2_ch] <= 1'b1;
        out_ch  <= s2_ch;
        vel_out <= vel_c;
        pos_out <= clr_hit ? '0 : sum_sat;
      end
      if (clr_valid) begin
        acc[clr_ch]       <= '0;
        sat_flags[clr_ch] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bemf_integrator.sv
// Directed self-checking bench for bemf_integrator with hand-computed expectations.
module tb_bemf_integrator;

  localparam int NUM_CH = 4;
  localparam int ADC_W  = 10;
  localparam int ACC_W  = 20;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [CH_W-1:0]   in_ch = '0;
  logic [ADC_W-1:0]  adc_h = '0;
  logic [ADC_W-1:0]  adc_l = '0;
  logic              calib_we = 1'b0;
  logic [CH_W-1:0]   calib_ch = '0;
  logic [ACC_W-1:0]  calib_data = '0;
  logic              clr_valid = 1'b0;
  logic [CH_W-1:0]   clr_ch = '0;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [ACC_W-1:0]  pos_out;
  logic [ACC_W-1:0]  vel_out;
  logic [NUM_CH-1:0] sat_flags;

  int n_assert = 0;
  int n_fail   = 0;
  logic [ACC_W-1:0] exp_q[$];

  bemf_integrator #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .ACC_W(ACC_W), .DEADBAND(20)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch),
    .adc_h(adc_h), .adc_l(adc_l), .calib_we(calib_we), .calib_ch(calib_ch),
    .calib_data(calib_data), .clr_valid(clr_valid), .clr_ch(clr_ch),
    .out_valid(out_valid), .out_ch(out_ch), .pos_out(pos_out),
    .vel_out(vel_out), .sat_flags(sat_flags)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: presents one sample for exactly one edge
  task automatic drive(input int ch, input int h, input int l);
    in_valid = 1'b1;
    in_ch    = CH_W'(ch);
    adc_h    = ADC_W'(h);
    adc_l    = ADC_W'(l);
    tick();
    in_valid = 1'b0;
  endtask

  // single sample, returns just after the edge where its result appears
  task automatic one_sample(input int ch, input int h, input int l);
    drive(ch, h, l);
    tick();
    tick();
    tick();
  endtask

  task automatic chk_out(input string tag, input int ch, input int pos, input int vel);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_ch"}, 32'(out_ch), ch);
    chk({tag, "_pos"}, 32'($signed(pos_out)), pos);
    chk({tag, "_vel"}, 32'($signed(vel_out)), vel);
  endtask

  task automatic calib_write(input int ch, input int val);
    calib_we   = 1'b1;
    calib_ch   = CH_W'(ch);
    calib_data = ACC_W'(val);
    tick();
    calib_we   = 1'b0;
  endtask

  // ch3 full-scale stream; result of sample k is visible after driving sample k+3
  task automatic sat_run();
    for (int i = 0; i < 520; i++) begin
      drive(3, 1023, 0);
      if (i - 3 == 511) begin
        chk("sat_pre_pos", 32'($signed(pos_out)), 523776);
        chk("sat_pre_flag", 32'(sat_flags[3]), 0);
      end
      if (i - 3 == 512) begin
        chk("sat_clamp_pos", 32'($signed(pos_out)), 524287);
        chk("sat_clamp_flag", 32'(sat_flags[3]), 1);
      end
      if (i - 3 == 516) begin
        chk("sat_hold_pos", 32'($signed(pos_out)), 524287);
        chk("sat_hold_vel", 32'($signed(vel_out)), 1023);
      end
    end
    tick();
    tick();
    tick();
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pos", 32'(pos_out), 0);
    chk("rst_flags", 32'(sat_flags), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // back-to-back accumulate on ch1
    exp_q.push_back(20'd500);
    exp_q.push_back(20'd1000);
    exp_q.push_back(20'd1500);
    drive(1, 600, 100);
    drive(1, 600, 100);
    drive(1, 600, 100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("b2b", 1, int'(exp_q.pop_front()), 500);
    end
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_pos_hold", 32'($signed(pos_out)), 1500);

    // deadband boundaries on ch0
    one_sample(0, 120, 100);  chk_out("db_p20", 0, 0, 0);
    one_sample(0, 121, 100);  chk_out("db_p21", 0, 21, 21);
    one_sample(0, 100, 121);  chk_out("db_m21", 0, 0, -21);
    one_sample(0, 100, 120);  chk_out("db_m20", 0, 0, 0);

    // calibration on ch2
    calib_write(2, 50);
    one_sample(2, 300, 100);  chk_out("cal50", 2, 150, 150);
    drive(2, 300, 100);
    tick();
    calib_write(2, 0);
    tick();
    chk_out("cal_race", 2, 300, 150);
    one_sample(2, 300, 100);  chk_out("cal0", 2, 500, 200);

    // interleaved ch0/ch1 (ch0=0, ch1=1500)
    drive(0, 200, 100);
    drive(1, 100, 400);
    drive(0, 200, 100);
    drive(1, 100, 400);
    chk_out("il0a", 0, 100, 100);
    tick();  chk_out("il1a", 1, 1200, -300);
    tick();  chk_out("il0b", 0, 200, 100);
    tick();  chk_out("il1b", 1, 900, -300);

    // clear colliding with ch0 commit
    drive(0, 200, 100);
    tick();
    tick();
    clr_valid = 1'b1;
    clr_ch    = 2'd0;
    tick();
    clr_valid = 1'b0;
    chk_out("clr_hit", 0, 0, 100);
    one_sample(0, 200, 100);  chk_out("after_clr0", 0, 100, 100);

    // clear of ch1 on a ch0 commit edge
    drive(0, 200, 100);
    tick();
    tick();
    clr_valid = 1'b1;
    clr_ch    = 2'd1;
    tick();
    clr_valid = 1'b0;
    chk_out("clr_other", 0, 200, 100);
    one_sample(1, 100, 400);  chk_out("after_clr1", 1, -300, -300);

    // saturation on ch3
    sat_run();
    chk("sat_flag_kept", 32'(sat_flags), 32'h8);

    // mid-stream reset: four ch1 samples, first result already out
    drive(1, 600, 100);
    drive(1, 600, 100);
    drive(1, 600, 100);
    drive(1, 600, 100);
    chk_out("pre_rst", 1, 200, 500);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_pos", 32'(pos_out), 0);
    chk("mrst_vel", 32'(vel_out), 0);
    chk("mrst_flags", 32'(sat_flags), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_flush", 32'(out_valid), 0);
    one_sample(1, 600, 100);  chk_out("post_rst", 1, 500, 500);

    // saturate ch3 again, then clear it
    sat_run();
    clr_valid = 1'b1;
    clr_ch    = 2'd3;
    tick();
    clr_valid = 1'b0;
    chk("clr3_flag", 32'(sat_flags[3]), 0);
    one_sample(3, 1023, 0);   chk_out("clr3_next", 3, 1023, 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
